// File: rtl/uc_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcode constants, ALU operation codes and the opcode classifier.
package uc_multiciclo_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [2:0] OP_ALU_PFX = 3'b000;
  localparam logic [5:0] OP_LOADI   = 6'b010000;
  localparam logic [5:0] OP_J       = 6'b100000;
  localparam logic [5:0] OP_JZ      = 6'b100001;
  localparam logic [5:0] OP_JNZ     = 6'b100010;
  localparam logic [5:0] OP_HALT    = 6'b111111;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_NOT = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;

  typedef enum logic [2:0] {
    C_ALU, C_LOADI, C_J, C_JZ, C_JNZ, C_HALT, C_ILL
  } iclass_e;

  function automatic iclass_e classify(input logic [5:0] opc);
    iclass_e c;
    if (opc[5:3] == OP_ALU_PFX)  c = C_ALU;
    else if (opc == OP_LOADI)    c = C_LOADI;
    else if (opc == OP_J)        c = C_J;
    else if (opc == OP_JZ)       c = C_JZ;
    else if (opc == OP_JNZ)      c = C_JNZ;
    else if (opc == OP_HALT)     c = C_HALT;
    else                         c = C_ILL;
    return c;
  endfunction

endpackage

// File: rtl/uc_multiciclo_fetch_wait_cnt.sv
// 4-bit load/decrement counter timing the program-memory read in FETCH.
// done is high once the count has reached zero.
module uc_multiciclo_fetch_wait_cnt (
  input  logic       clk,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt_p0;

  always_ff @(posedge clk) begin
    if (load)
      cnt_p0 <= load_val;
    else if (dec && (cnt_p0 != 4'd0))
      cnt_p0 <= cnt_p0 - 4'd1;
  end

  assign done = (cnt_p0 == 4'd0);

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH -> DECODE -> EXEC with run/step/halt control.
// Optional retired-instruction counter enabled by defining INSTR_CNT_EN.
module uc_multiciclo
  import uc_multiciclo_pkg::*;
#(
  parameter int FETCH_WAIT = 1
`ifdef INSTR_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       run,
  input  logic       step,
  output logic       pc_we,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] op_alu,
  output logic       busy,
  output logic       halted,
  output logic       err,
  output logic       instr_done
`ifdef INSTR_CNT_EN
  , output logic [CNT_W-1:0] instr_cnt
`endif
);

  state_e  state_q, state_d;
  logic    oneshot_q, oneshot_d;
  logic    err_q, err_d;
  logic    wait_done;
  iclass_e iclass;

  uc_multiciclo_fetch_wait_cnt u_wait (
    .clk      (clk),
    .load     (state_q != S_FETCH),
    .load_val (4'(FETCH_WAIT - 1)),
    .dec      (state_q == S_FETCH),
    .done     (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      oneshot_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      oneshot_q <= oneshot_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    oneshot_d  = oneshot_q;
    err_d      = err_q;
    pc_we      = 1'b0;
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    we3        = 1'b0;
    wez        = 1'b0;
    op_alu     = ALU_NOP;
    instr_done = 1'b0;
    iclass     = classify(opcode);

    // Datapath selects follow the opcode throughout DECODE and EXEC
    if (state_q == S_DECODE || state_q == S_EXEC) begin
      case (iclass)
        C_ALU:   op_alu = opcode[2:0];
        C_LOADI: s_inm  = 1'b1;
        C_J:     s_inc  = 1'b0;
        C_JZ:    s_inc  = ~z;
        C_JNZ:   s_inc  = z;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d   = S_FETCH;
          oneshot_d = 1'b0;
        end else if (step) begin
          state_d   = S_FETCH;
          oneshot_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (wait_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          C_HALT:  state_d = S_HALT;
          C_ILL: begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        pc_we      = 1'b1;
        instr_done = 1'b1;
        we3        = (iclass == C_ALU) || (iclass == C_LOADI);
        wez        = (iclass == C_ALU);
        if (run && !oneshot_q) begin
          state_d = S_FETCH;
        end else begin
          state_d   = S_IDLE;
          oneshot_d = 1'b0;
        end
      end
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase

    // A reset cycle aborts whatever is in flight: no architectural writes
    if (reset) begin
      pc_we      = 1'b0;
      s_inc      = 1'b1;
      s_inm      = 1'b0;
      we3        = 1'b0;
      wez        = 1'b0;
      op_alu     = ALU_NOP;
      instr_done = 1'b0;
    end
  end

  assign busy   = !reset && (state_q == S_FETCH || state_q == S_DECODE || state_q == S_EXEC);
  assign halted = !reset && (state_q == S_HALT);
  assign err    = !reset && err_q;

`ifdef INSTR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (instr_done)
      cnt_q <= cnt_q + 1'b1;
  end

  assign instr_cnt = reset ? '0 : cnt_q;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: program run, jumps, stepping, illegal
// opcode, reset in EXEC, and FETCH_WAIT=3 timing with the optional counter.
module tb_uc_multiciclo;

  logic       clk = 1'b0;
  logic       reset, z, run, step;
  logic [5:0] opcode;
  logic       pc_we, s_inc, s_inm, we3, wez, busy, halted, err, instr_done;
  logic [2:0] op_alu;

  logic       reset_w, z_w, run_w, step_w;
  logic [5:0] opcode_w;
  logic       pc_we_w, s_inc_w, s_inm_w, we3_w, wez_w, busy_w, halted_w, err_w, instr_done_w;
  logic [2:0] op_alu_w;
`ifdef INSTR_CNT_EN
  logic [15:0] instr_cnt;
  logic [3:0]  instr_cnt_w;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  uc_multiciclo #(.FETCH_WAIT(1)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .run(run), .step(step),
    .pc_we(pc_we), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
    .op_alu(op_alu), .busy(busy), .halted(halted), .err(err), .instr_done(instr_done)
`ifdef INSTR_CNT_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  uc_multiciclo #(
    .FETCH_WAIT(3)
`ifdef INSTR_CNT_EN
    , .CNT_W(4)
`endif
  ) u_w3 (
    .clk(clk), .reset(reset_w), .opcode(opcode_w), .z(z_w), .run(run_w), .step(step_w),
    .pc_we(pc_we_w), .s_inc(s_inc_w), .s_inm(s_inm_w), .we3(we3_w), .wez(wez_w),
    .op_alu(op_alu_w), .busy(busy_w), .halted(halted_w), .err(err_w), .instr_done(instr_done_w)
`ifdef INSTR_CNT_EN
    , .instr_cnt(instr_cnt_w)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0; step = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; z = 1'b0; opcode = 6'b000010;
    tick(); tick();
    vecs++; if (pc_we !== 1'b0)  begin errs++; $display("FAIL rst_pc_we: got %b expected 0", pc_we); end
    vecs++; if (s_inc !== 1'b1)  begin errs++; $display("FAIL rst_s_inc: got %b expected 1", s_inc); end
    vecs++; if (s_inm !== 1'b0)  begin errs++; $display("FAIL rst_s_inm: got %b expected 0", s_inm); end
    vecs++; if (we3 !== 1'b0)    begin errs++; $display("FAIL rst_we3: got %b expected 0", we3); end
    vecs++; if (wez !== 1'b0)    begin errs++; $display("FAIL rst_wez: got %b expected 0", wez); end
    vecs++; if (op_alu !== 3'd0) begin errs++; $display("FAIL rst_op_alu: got %0d expected 0", op_alu); end
    vecs++; if (busy !== 1'b0)   begin errs++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL rst_halted: got %b expected 0", halted); end
    vecs++; if (err !== 1'b0)    begin errs++; $display("FAIL rst_err: got %b expected 0", err); end
    vecs++; if (instr_done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b expected 0", instr_done); end
    reset = 1'b0;
    #1;
  endtask

  // LOADI R1,5 ; ALU add ; HALT with a small PC model advancing on pc_we
  task automatic test_program();
    logic [5:0] prog [3];
    int  pc;
    bit  adv;
    logic exp_done;
    prog[0] = 6'b010000; prog[1] = 6'b000010; prog[2] = 6'b111111;
    do_reset();
    pc = 0; adv = 1'b0; z = 1'b0; opcode = prog[0]; run = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (adv) pc++;
      adv = 1'b0;
      opcode = (pc < 3) ? prog[pc] : 6'b111111;
      #1;
      exp_done = (cyc == 3 || cyc == 6);
      vecs++;
      if (instr_done !== exp_done) begin
        errs++; $display("FAIL prog_done cyc%0d: got %b expected %b", cyc, instr_done, exp_done);
      end
      if (cyc == 3) begin
        vecs++; if ({we3, s_inm, wez, pc_we} !== 4'b1101) begin
          errs++; $display("FAIL prog_loadi {we3,s_inm,wez,pc_we}: got %b expected 1101", {we3, s_inm, wez, pc_we});
        end
      end
      if (cyc == 6) begin
        vecs++; if ({we3, wez, s_inm, op_alu} !== 6'b110_010) begin
          errs++; $display("FAIL prog_alu {we3,wez,s_inm,op_alu}: got %b expected 110010", {we3, wez, s_inm, op_alu});
        end
      end
      if (cyc >= 9) begin
        vecs++; if (halted !== 1'b1) begin errs++; $display("FAIL prog_halted cyc%0d: got %b expected 1", cyc, halted); end
      end
      if (pc_we === 1'b1) adv = 1'b1;
    end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL prog_err: got %b expected 0", err); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL prog_busy: got %b expected 0", busy); end
`ifdef INSTR_CNT_EN
    vecs++; if (instr_cnt !== 16'd2) begin errs++; $display("FAIL prog_cnt: got %0d expected 2", instr_cnt); end
`endif
    run = 1'b0;
  endtask

  task automatic test_jumps();
    logic [5:0] opc [5];
    logic       zv  [5];
    logic       exp [5];
    opc[0] = 6'b100001; zv[0] = 1'b1; exp[0] = 1'b0;
    opc[1] = 6'b100001; zv[1] = 1'b0; exp[1] = 1'b1;
    opc[2] = 6'b100000; zv[2] = 1'b0; exp[2] = 1'b0;
    opc[3] = 6'b100010; zv[3] = 1'b1; exp[3] = 1'b1;
    opc[4] = 6'b100010; zv[4] = 1'b0; exp[4] = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      opcode = opc[i]; z = zv[i]; step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      vecs++; if (s_inc !== exp[i]) begin errs++; $display("FAIL jmp%0d_dec_s_inc: got %b expected %b", i, s_inc, exp[i]); end
      tick();
      vecs++; if ({pc_we, s_inc, we3, wez} !== {1'b1, exp[i], 2'b00}) begin
        errs++; $display("FAIL jmp%0d_exec {pc_we,s_inc,we3,wez}: got %b expected %b", i, {pc_we, s_inc, we3, wez}, {1'b1, exp[i], 2'b00});
      end
      tick();
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL jmp%0d_idle busy: got %b expected 0", i, busy); end
    end
  endtask

  task automatic test_step();
    int cnt;
    do_reset();
    opcode = 6'b000010; z = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      cnt = 0;
      repeat (8) begin tick(); cnt += int'(instr_done); end
      vecs++; if (cnt != 1) begin errs++; $display("FAIL step%0d_count: got %0d expected 1", k, cnt); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL step%0d_idle busy: got %b expected 0", k, busy); end
    end
    run = 1'b1; step = 1'b1;
    cnt = 0;
    repeat (9) begin tick(); cnt += int'(instr_done); end
    vecs++; if (cnt != 3) begin errs++; $display("FAIL step_with_run count: got %0d expected 3", cnt); end
    run = 1'b0; step = 1'b0;
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL run_stop busy: got %b expected 0", busy); end
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick();
    vecs++; if (instr_done !== 1'b1) begin errs++; $display("FAIL run_drop done: got %b expected 1", instr_done); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL run_drop idle busy: got %b expected 0", busy); end
  endtask

  task automatic test_illegal();
    int bad;
    do_reset();
    opcode = 6'b011111; run = 1'b1; bad = 0;
    repeat (8) begin
      tick();
      if (pc_we || we3 || wez || instr_done) bad++;
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL ill_writes: got %0d expected 0", bad); end
    vecs++; if ({halted, err} !== 2'b11) begin errs++; $display("FAIL ill_state {halted,err}: got %b expected 11", {halted, err}); end
    run = 1'b0; step = 1'b1;
    repeat (4) tick();
    step = 1'b0;
    vecs++; if ({halted, err, busy} !== 3'b110) begin
      errs++; $display("FAIL ill_absorb {halted,err,busy}: got %b expected 110", {halted, err, busy});
    end
    reset = 1'b1;
    #1;
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL ill_rst_cycle err: got %b expected 0", err); end
    tick();
    reset = 1'b0;
    #1;
    vecs++; if ({halted, err} !== 2'b00) begin errs++; $display("FAIL ill_after_rst {halted,err}: got %b expected 00", {halted, err}); end
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    opcode = 6'b000010; z = 1'b0; run = 1'b1;
    tick(); tick(); tick();
    vecs++; if ({pc_we, we3, wez} !== 3'b111) begin errs++; $display("FAIL rie_exec: got %b expected 111", {pc_we, we3, wez}); end
    reset = 1'b1; run = 1'b0;
    #1;
    vecs++; if ({pc_we, we3, wez, instr_done, s_inc} !== 5'b00001) begin
      errs++; $display("FAIL rie_abort {pc_we,we3,wez,done,s_inc}: got %b expected 00001", {pc_we, we3, wez, instr_done, s_inc});
    end
    tick();
    reset = 1'b0;
    #1;
    vecs++; if ({busy, halted, err, s_inc, s_inm, op_alu} !== 8'b0001_0_000) begin
      errs++; $display("FAIL rie_after {busy,halted,err,s_inc,s_inm,op_alu}: got %b expected 00010000", {busy, halted, err, s_inc, s_inm, op_alu});
    end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rie_idle busy: got %b expected 0", busy); end
  endtask

  task automatic test_wait_and_cnt();
    logic exp_done;
    run_w = 1'b0; step_w = 1'b0; z_w = 1'b0; opcode_w = 6'b000010;
    reset_w = 1'b1;
    tick(); tick();
    reset_w = 1'b0; run_w = 1'b1;
    for (int cyc = 1; cyc <= 85; cyc++) begin
      tick();
      exp_done = (cyc % 5 == 0);
      vecs++;
      if (instr_done_w !== exp_done) begin
        errs++; $display("FAIL w3_done cyc%0d: got %b expected %b", cyc, instr_done_w, exp_done);
      end
`ifdef INSTR_CNT_EN
      if (cyc == 81) begin
        vecs++; if (instr_cnt_w !== 4'd0) begin errs++; $display("FAIL w3_cnt_wrap: got %0d expected 0", instr_cnt_w); end
      end
`endif
    end
    run_w = 1'b0;
    tick();
`ifdef INSTR_CNT_EN
    vecs++; if (instr_cnt_w !== 4'd1) begin errs++; $display("FAIL w3_cnt_17: got %0d expected 1", instr_cnt_w); end
`endif
    vecs++; if (busy_w !== 1'b0) begin errs++; $display("FAIL w3_idle busy: got %b expected 0", busy_w); end
  endtask

  initial begin
    reset_w = 1'b1; run_w = 1'b0; step_w = 1'b0; z_w = 1'b0; opcode_w = 6'b000000;
    test_reset();
    test_program();
    test_jumps();
    test_step();
    test_illegal();
    test_reset_in_exec();
    test_wait_and_cnt();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
